// File: rtl/hps_reset_req_gen.sv
// Fabric-side HPS reset-request generator: debounced pushbutton gives warm (short)
// or cold (long) requests, dbg_req gives debug requests, each followed by a hold-off.
module hps_reset_req_gen #(
  parameter int DEBOUNCE_CYCLES   = 50000,
  parameter int LONG_PRESS_CYCLES = 100000000,
  parameter int PULSE_CYCLES      = 16,
  parameter int HOLDOFF_CYCLES    = 1000
) (
  input  logic       clk_clk,
  input  logic       reset_reset,
  input  logic       key_n,
  input  logic       dbg_req,
  input  logic       h2f_reset_n,
  output logic       f2h_warm_reset_req_n,
  output logic       f2h_cold_reset_req_n,
  output logic       f2h_debug_reset_req_n,
  output logic       busy,
  output logic [1:0] last_req
);

  localparam int DB_W = (DEBOUNCE_CYCLES   > 1) ? $clog2(DEBOUNCE_CYCLES)   : 1;
  localparam int LP_W = (LONG_PRESS_CYCLES > 1) ? $clog2(LONG_PRESS_CYCLES) : 1;
  localparam int PW_W = (PULSE_CYCLES      > 1) ? $clog2(PULSE_CYCLES)      : 1;
  localparam int HO_W = (HOLDOFF_CYCLES    > 1) ? $clog2(HOLDOFF_CYCLES)    : 1;

  // Press and hold-off leave their state on the edge where the counter reaches N-1,
  // so the comparison is made against N-2 on the value before that edge.
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LP_W-1:0] LP_LAST = LP_W'((LONG_PRESS_CYCLES > 1) ? LONG_PRESS_CYCLES - 2 : 0);
  localparam logic [PW_W-1:0] PW_LAST = PW_W'(PULSE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_LAST = HO_W'((HOLDOFF_CYCLES > 1) ? HOLDOFF_CYCLES - 2 : 0);

  localparam logic [1:0] REQ_NONE  = 2'b00;
  localparam logic [1:0] REQ_WARM  = 2'b01;
  localparam logic [1:0] REQ_COLD  = 2'b10;
  localparam logic [1:0] REQ_DEBUG = 2'b11;

  typedef enum logic [2:0] {
    REARM   = 3'd0,
    IDLE    = 3'd1,
    PRESSED = 3'd2,
    PULSE   = 3'd3,
    HOLDOFF = 3'd4
  } state_t;

  state_t            state_reg, state_next;
  logic [1:0]        kind_reg, kind_next;
  logic              key_meta_reg, key_sync_reg;
  logic              key_db_reg;
  logic [DB_W-1:0]   db_cnt_reg;
  logic [LP_W-1:0]   press_cnt_reg;
  logic [PW_W-1:0]   pulse_cnt_reg;
  logic [HO_W-1:0]   hold_cnt_reg;
  logic [2:0]        req_n_reg, req_n_next;
  logic              busy_reg, busy_next;
  logic [1:0]        last_req_reg, last_req_next;

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_meta_reg <= 1'b1;
      key_sync_reg <= 1'b1;
    end else begin
      key_meta_reg <= key_n;
      key_sync_reg <= key_meta_reg;
    end
  end

  // key_db starts at "pressed" so the FSM must first see a clean release.
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      key_db_reg <= 1'b0;
      db_cnt_reg <= '0;
    end else if (key_sync_reg == key_db_reg) begin
      db_cnt_reg <= '0;
    end else if (db_cnt_reg == DB_LAST) begin
      key_db_reg <= ~key_db_reg;
      db_cnt_reg <= '0;
    end else if (~&db_cnt_reg) begin
      db_cnt_reg <= db_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      press_cnt_reg <= '0;
      pulse_cnt_reg <= '0;
      hold_cnt_reg  <= '0;
    end else begin
      if (state_reg != PRESSED)
        press_cnt_reg <= '0;
      else if (~&press_cnt_reg)
        press_cnt_reg <= press_cnt_reg + 1'b1;

      if (state_reg != PULSE)
        pulse_cnt_reg <= '0;
      else if (~&pulse_cnt_reg)
        pulse_cnt_reg <= pulse_cnt_reg + 1'b1;

      if (state_reg != HOLDOFF || !h2f_reset_n)
        hold_cnt_reg <= '0;
      else if (~&hold_cnt_reg)
        hold_cnt_reg <= hold_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_reg    <= REARM;
      kind_reg     <= REQ_NONE;
      req_n_reg    <= '1;
      busy_reg     <= 1'b0;
      last_req_reg <= REQ_NONE;
    end else begin
      state_reg    <= state_next;
      kind_reg     <= kind_next;
      req_n_reg    <= req_n_next;
      busy_reg     <= busy_next;
      last_req_reg <= last_req_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    kind_next  = kind_reg;
    case (state_reg)
      REARM: begin
        if (key_db_reg)
          state_next = IDLE;
      end
      IDLE: begin
        // A press in the same cycle as dbg_req takes priority; the strobe is lost.
        if (!key_db_reg) begin
          state_next = PRESSED;
        end else if (dbg_req) begin
          state_next = PULSE;
          kind_next  = REQ_DEBUG;
        end
      end
      PRESSED: begin
        if (key_db_reg) begin
          state_next = PULSE;
          kind_next  = REQ_WARM;
        end else if (press_cnt_reg >= LP_LAST) begin
          state_next = PULSE;
          kind_next  = REQ_COLD;
        end
      end
      PULSE: begin
        if (pulse_cnt_reg == PW_LAST)
          state_next = HOLDOFF;
      end
      HOLDOFF: begin
        if (h2f_reset_n && hold_cnt_reg >= HO_LAST)
          state_next = REARM;
      end
      default: begin
        state_next = REARM;
      end
    endcase
  end

  // Outputs are computed from the next state so they change on the same edge.
  always_comb begin
    busy_next     = (state_next != IDLE);
    last_req_next = last_req_reg;
    if (state_next == PULSE && state_reg != PULSE)
      last_req_next = kind_next;
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_req
      assign req_n_next[gi] = ~(state_next == PULSE && kind_next == 2'(gi + 1));
    end
  endgenerate

  assign f2h_warm_reset_req_n  = req_n_reg[0];
  assign f2h_cold_reset_req_n  = req_n_reg[1];
  assign f2h_debug_reset_req_n = req_n_reg[2];
  assign busy                  = busy_reg;
  assign last_req              = last_req_reg;

endmodule

// File: tb/tb_hps_reset_req_gen.sv
// Bench for hps_reset_req_gen: directed scenarios plus random key/dbg/h2f traffic,
// every cycle compared against a behavioural model of the request rules.
module tb_hps_reset_req_gen;
  localparam int DB = 4;
  localparam int LP = 40;
  localparam int PW = 3;
  localparam int HO = 8;

  logic       clk_clk = 1'b0;
  logic       reset_reset = 1'b1;
  logic       key_n = 1'b1;
  logic       dbg_req = 1'b0;
  logic       h2f_reset_n = 1'b1;
  logic       warm_n, cold_n, debug_n, busy;
  logic [1:0] last_req;

  hps_reset_req_gen #(
    .DEBOUNCE_CYCLES  (DB),
    .LONG_PRESS_CYCLES(LP),
    .PULSE_CYCLES     (PW),
    .HOLDOFF_CYCLES   (HO)
  ) dut (
    .clk_clk              (clk_clk),
    .reset_reset          (reset_reset),
    .key_n                (key_n),
    .dbg_req              (dbg_req),
    .h2f_reset_n          (h2f_reset_n),
    .f2h_warm_reset_req_n (warm_n),
    .f2h_cold_reset_req_n (cold_n),
    .f2h_debug_reset_req_n(debug_n),
    .busy                 (busy),
    .last_req             (last_req)
  );

  always #5 clk_clk = ~clk_clk;

  int total = 0;
  int bad   = 0;

  task automatic check_val(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: key delay line, debounced level, and the request life cycle
  // described as "waiting for release / pressing / pulse remaining / hold-off progress".
  int kq[$];
  int m_db, m_run;
  bit m_rearm, m_hold, m_busy;
  int m_press, m_pulse_left, m_kind, m_hold_ones, m_last;

  task automatic m_reset();
    kq = {1, 1};
    m_db = 0; m_run = 0;
    m_rearm = 1; m_hold = 0; m_busy = 0;
    m_press = -1; m_pulse_left = 0; m_kind = 0; m_hold_ones = 0; m_last = 0;
  endtask

  task automatic fire(int k);
    m_pulse_left = PW;
    m_kind = k;
    m_last = k;
    m_press = -1;
  endtask

  task automatic m_step(int k, int d, int h);
    int sample;
    sample = kq.pop_front();
    kq.push_back(k);
    if (m_pulse_left > 0) begin
      m_pulse_left--;
      if (m_pulse_left == 0) begin
        m_hold = 1;
        m_hold_ones = 0;
      end
    end else if (m_hold) begin
      if (h == 0) m_hold_ones = 0;
      else begin
        m_hold_ones++;
        if (m_hold_ones >= HO - 1) begin
          m_hold = 0;
          m_rearm = 1;
        end
      end
    end else if (m_rearm) begin
      if (m_db == 1) m_rearm = 0;
    end else if (m_press >= 0) begin
      if (m_db == 1) fire(1);
      else begin
        m_press++;
        if (m_press >= LP - 1) fire(2);
      end
    end else begin
      if (m_db == 0) m_press = 0;
      else if (d != 0) fire(3);
    end
    m_busy = m_rearm || (m_press >= 0) || (m_pulse_left > 0) || m_hold;
    if (sample != m_db) begin
      m_run++;
      if (m_run == DB) begin
        m_db = 1 - m_db;
        m_run = 0;
      end
    end else m_run = 0;
  endtask

  // Scenario observations taken from the DUT outputs.
  int scn_cyc, n_low, first_low, n_warm, n_cold, n_dbg;
  logic prev_w = 1'b1, prev_c = 1'b1, prev_d = 1'b1;

  task automatic scn_begin();
    scn_cyc = 0; n_low = 0; first_low = -1; n_warm = 0; n_cold = 0; n_dbg = 0;
  endtask

  task automatic compare_all();
    int lows;
    check_val("warm_n",  warm_n,   (m_pulse_left > 0 && m_kind == 1) ? 0 : 1);
    check_val("cold_n",  cold_n,   (m_pulse_left > 0 && m_kind == 2) ? 0 : 1);
    check_val("debug_n", debug_n,  (m_pulse_left > 0 && m_kind == 3) ? 0 : 1);
    check_val("busy",    busy,     m_busy ? 1 : 0);
    check_val("last_req", last_req, m_last);
    lows = 0;
    if (!warm_n)  lows++;
    if (!cold_n)  lows++;
    if (!debug_n) lows++;
    check_val("one_low", (lows <= 1) ? 1 : 0, 1);
    if (lows > 0) begin
      n_low++;
      if (first_low < 0) first_low = scn_cyc;
    end
    if (!warm_n  && prev_w) n_warm++;
    if (!cold_n  && prev_c) n_cold++;
    if (!debug_n && prev_d) n_dbg++;
    prev_w = warm_n; prev_c = cold_n; prev_d = debug_n;
  endtask

  task automatic cycle();
    @(posedge clk_clk);
    if (reset_reset) m_reset();
    else m_step(int'(key_n), int'(dbg_req), int'(h2f_reset_n));
    @(negedge clk_clk);
    scn_cyc++;
    compare_all();
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    m_reset();
    scn_begin();
    run(2);

    // 1: reset release with key up; no pulse ever.
    reset_reset = 1'b0;
    scn_begin();
    run(12);
    check_val("s1_busy", busy, 0);
    check_val("s1_low_cycles", n_low, 0);
    $display("scenario 1 reset release: low_cycles=%0d busy=%0d", n_low, busy);

    // 2: bounced short press -> one warm pulse.
    scn_begin();
    key_n = 1'b0; run(2);
    key_n = 1'b1; run(1);
    key_n = 1'b0; run(12);
    key_n = 1'b1; run(30);
    check_val("s2_warm_pulses", n_warm, 1);
    check_val("s2_cold_pulses", n_cold, 0);
    check_val("s2_low_cycles", n_low, PW);
    check_val("s2_first_low", first_low, 22);
    check_val("s2_last_req", last_req, 1);
    $display("scenario 2 short press: warm=%0d low_cycles=%0d first_low=%0d", n_warm, n_low, first_low);

    // 3: long hold -> cold pulse, nothing on release.
    scn_begin();
    key_n = 1'b0; run(70);
    key_n = 1'b1; run(20);
    check_val("s3_cold_pulses", n_cold, 1);
    check_val("s3_warm_pulses", n_warm, 0);
    check_val("s3_low_cycles", n_low, PW);
    check_val("s3_first_low", first_low, 46);
    check_val("s3_last_req", last_req, 2);
    $display("scenario 3 long press: cold=%0d warm=%0d first_low=%0d", n_cold, n_warm, first_low);

    // 4: debug strobe, then a second one during hold-off.
    scn_begin();
    dbg_req = 1'b1; run(1);
    dbg_req = 1'b0; run(5);
    dbg_req = 1'b1; run(1);
    dbg_req = 1'b0; run(20);
    check_val("s4_dbg_pulses", n_dbg, 1);
    check_val("s4_low_cycles", n_low, PW);
    check_val("s4_first_low", first_low, 1);
    check_val("s4_last_req", last_req, 3);
    $display("scenario 4 debug: dbg=%0d low_cycles=%0d", n_dbg, n_low);

    // 5: warm pulse, then h2f_reset_n low for 20 clocks in hold-off.
    scn_begin();
    key_n = 1'b0; run(8);
    key_n = 1'b1;
    cnt = 0;
    while (n_warm == 0 && cnt < 100) begin cycle(); cnt++; end
    while (!warm_n && cnt < 100) begin cycle(); cnt++; end
    check_val("s5_pulse_seen", (cnt < 100) ? 1 : 0, 1);
    h2f_reset_n = 1'b0; run(20);
    check_val("s5_busy_during_h2f_low", busy, 1);
    h2f_reset_n = 1'b1;
    cnt = 0;
    while (busy && cnt < 50) begin cycle(); cnt++; end
    check_val("s5_busy_fall_delay", cnt, HO);
    $display("scenario 5 holdoff: busy fell %0d clocks after h2f release", cnt);

    // 6: async reset in the 2nd pulse cycle with the key held down.
    scn_begin();
    key_n = 1'b0;
    cnt = 0;
    while (n_low == 0 && cnt < 100) begin cycle(); cnt++; end
    check_val("s6_pulse_seen", (cnt < 100) ? 1 : 0, 1);
    cycle();
    check_val("s6_second_cycle_low", cold_n, 0);
    #2 reset_reset = 1'b1;
    #1;
    m_reset();
    check_val("s6_async_warm", warm_n, 1);
    check_val("s6_async_cold", cold_n, 1);
    check_val("s6_async_debug", debug_n, 1);
    check_val("s6_async_busy", busy, 0);
    check_val("s6_async_last", last_req, 0);
    run(2);
    reset_reset = 1'b0;
    scn_begin();
    run(30);
    check_val("s6_held_no_pulse", n_low, 0);
    key_n = 1'b1; run(10);
    key_n = 1'b0; run(8);
    key_n = 1'b1; run(30);
    check_val("s6_repress_warm", n_warm, 1);
    $display("scenario 6 reset mid-pulse: pulses after re-press warm=%0d", n_warm);

    // Random traffic.
    for (int i = 0; i < 150; i++) begin
      int a;
      a = $urandom_range(0, 4);
      scn_begin();
      case (a)
        0: begin
          key_n = 1'b0; run($urandom_range(1, 60));
          key_n = 1'b1; run($urandom_range(1, 20));
        end
        1: begin
          dbg_req = 1'b1; run(1);
          dbg_req = 1'b0; run($urandom_range(0, 10));
        end
        2: begin
          h2f_reset_n = 1'b0; run($urandom_range(1, 15));
          h2f_reset_n = 1'b1; run($urandom_range(0, 10));
        end
        3: begin
          key_n = 1'($urandom_range(0, 1));
          dbg_req = 1'($urandom_range(0, 1));
          h2f_reset_n = 1'($urandom_range(0, 1));
          run($urandom_range(1, 4));
          dbg_req = 1'b0;
          h2f_reset_n = 1'b1;
        end
        default: begin
          reset_reset = 1'b1; run($urandom_range(1, 3));
          reset_reset = 1'b0; run(1);
        end
      endcase
      $display("random %0d action=%0d cycles=%0d low_cycles=%0d last_req=%0d", i, a, scn_cyc, n_low, last_req);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
